// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM tile sequencer: FSM state
// encoding, default array geometry and a ceiling-divide helper.
package gemm_pkg;

  localparam int ROWS_DEF   = 4;
  localparam int COLS_DEF   = 4;
  localparam int SA_LAT_DEF = ROWS_DEF + COLS_DEF - 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FEED,
    DRAIN,
    WRITE,
    NEXT,
    DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/gemm_loop_counter.sv
// Modulo-limit loop counter: counts 0..limit-1 while enabled, wraps to 0,
// and flags the wrapping cycle combinationally.
module gemm_loop_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DIM_W-1:0] limit,
  output logic [DIM_W-1:0] count,
  output logic             wrap
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic last;

  assign last = (count == limit - ONE);
  assign wrap = en && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Tiles an M x K x N GEMM onto a ROWS x COLS systolic array, sequencing
// A/B reads, clear/feed/drain and C write-back per output tile.
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int DIM_W      = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int SA_LAT     = ROWS + COLS - 1,
  localparam int RSW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIM_W-1:0]      M_dimension,
  input  logic [DIM_W-1:0]      K_dimension,
  input  logic [DIM_W-1:0]      N_dimension,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en_A,
  output logic [ADDR_WIDTH-1:0] addr_A,
  output logic                  rd_en_B,
  output logic [ADDR_WIDTH-1:0] addr_B,
  output logic                  sa_clear,
  output logic                  sa_feed,
  output logic [ROWS-1:0]       row_mask,
  output logic [COLS-1:0]       col_mask,
  output logic [RSW-1:0]        sa_row_sel,
  output logic                  wr_en_C,
  output logic [ADDR_WIDTH-1:0] addr_C,
  output state_t                dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is low for the whole run.

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t state, state_nx;

  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [DIM_W-1:0] mt_lim, nt_lim, m_rem, n_rem, ph_lim;
  logic [DIM_W-1:0] k_cnt, ph_cnt, nt_cnt, mt_cnt;
  logic             k_en, ph_en, nt_en, mt_en, cnt_clr;
  logic             k_wrap, ph_wrap, nt_wrap, mt_wrap;
  logic             accept, zero_dim, active;
  logic [ADDR_WIDTH-1:0] a_base, b_base, c_base, k_ext;
  logic [ROWS-1:0]  row_mask_c;
  logic [COLS-1:0]  col_mask_c;

  function automatic logic [DIM_W-1:0] edge_rem(input logic [DIM_W-1:0] d, input int t);
    int r;
    r = int'(d) % t;
    return (r == 0) ? DIM_W'(t) : DIM_W'(r);
  endfunction

  assign busy      = (state != IDLE);
  assign in_ready  = !busy;
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign zero_dim  = (M_dimension == '0) || (K_dimension == '0) || (N_dimension == '0);
  assign active    = (state == FEED) || (state == DRAIN) || (state == WRITE);
  assign k_ext     = ADDR_WIDTH'(k_q);

  assign cnt_clr = (state == SETUP);
  assign k_en    = (state == FEED);
  assign ph_en   = (state == DRAIN) || (state == WRITE);
  assign nt_en   = (state == NEXT);
  assign mt_en   = nt_wrap;
  assign ph_lim  = (state == WRITE) ? DIM_W'(ROWS) : DIM_W'(SA_LAT);

  gemm_loop_counter #(.DIM_W(DIM_W)) u_k_cnt (
    .clk(clk), .rst_n(reset_n), .clear(cnt_clr), .en(k_en),
    .limit(k_q), .count(k_cnt), .wrap(k_wrap)
  );

  gemm_loop_counter #(.DIM_W(DIM_W)) u_ph_cnt (
    .clk(clk), .rst_n(reset_n), .clear(cnt_clr), .en(ph_en),
    .limit(ph_lim), .count(ph_cnt), .wrap(ph_wrap)
  );

  gemm_loop_counter #(.DIM_W(DIM_W)) u_nt_cnt (
    .clk(clk), .rst_n(reset_n), .clear(cnt_clr), .en(nt_en),
    .limit(nt_lim), .count(nt_cnt), .wrap(nt_wrap)
  );

  // mt only advances when nt wraps, so its wrap marks the final tile.
  gemm_loop_counter #(.DIM_W(DIM_W)) u_mt_cnt (
    .clk(clk), .rst_n(reset_n), .clear(cnt_clr), .en(mt_en),
    .limit(mt_lim), .count(mt_cnt), .wrap(mt_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !zero_dim) state_nx = SETUP;
      SETUP:   state_nx = FEED;
      FEED:    if (k_wrap) state_nx = DRAIN;
      DRAIN:   if (ph_wrap) state_nx = WRITE;
      WRITE:   if (ph_wrap) state_nx = NEXT;
      NEXT:    state_nx = mt_wrap ? DONE : FEED;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q    <= '0;
      k_q    <= '0;
      n_q    <= '0;
      mt_lim <= '0;
      nt_lim <= '0;
      m_rem  <= '0;
      n_rem  <= '0;
    end else begin
      if (accept) begin
        m_q <= M_dimension;
        k_q <= K_dimension;
        n_q <= N_dimension;
      end
      if (state == SETUP) begin
        mt_lim <= DIM_W'(ceil_div(int'(m_q), ROWS));
        nt_lim <= DIM_W'(ceil_div(int'(n_q), COLS));
        m_rem  <= edge_rem(m_q, ROWS);
        n_rem  <= edge_rem(n_q, COLS);
      end
    end
  end

  // Base registers step by K (A/B) and ROWS (C) per tile instead of multiplying.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
    end else if (state == SETUP) begin
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
    end else if (state == NEXT) begin
      c_base <= c_base + ADDR_WIDTH'(ROWS);
      if (nt_wrap) begin
        b_base <= '0;
        a_base <= a_base + k_ext;
      end else begin
        b_base <= b_base + k_ext;
      end
    end
  end

  always_comb begin
    row_mask_c = '0;
    col_mask_c = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_mask_c[i] = (mt_cnt != mt_lim - ONE) || (DIM_W'(i) < m_rem);
    end
    for (int j = 0; j < COLS; j++) begin
      col_mask_c[j] = (nt_cnt != nt_lim - ONE) || (DIM_W'(j) < n_rem);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_A    <= 1'b0;
      rd_en_B    <= 1'b0;
      addr_A     <= '0;
      addr_B     <= '0;
      sa_clear   <= 1'b0;
      sa_feed    <= 1'b0;
      row_mask   <= '0;
      col_mask   <= '0;
      sa_row_sel <= '0;
      wr_en_C    <= 1'b0;
      addr_C     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_en_A    <= (state == FEED);
      rd_en_B    <= (state == FEED);
      sa_feed    <= (state == FEED);
      sa_clear   <= (state == FEED) && (k_cnt == '0);
      addr_A     <= (state == FEED) ? a_base + ADDR_WIDTH'(k_cnt) : '0;
      addr_B     <= (state == FEED) ? b_base + ADDR_WIDTH'(k_cnt) : '0;
      row_mask   <= active ? row_mask_c : '0;
      col_mask   <= active ? col_mask_c : '0;
      sa_row_sel <= (state == WRITE) ? ph_cnt[RSW-1:0] : '0;
      wr_en_C    <= (state == WRITE) && row_mask_c[ph_cnt[RSW-1:0]];
      addr_C     <= (state == WRITE) ? c_base + ADDR_WIDTH'(ph_cnt) : '0;
      done       <= (state == DONE);
      err        <= accept && zero_dim;
    end
  end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: address/mask/latency checks
// against hand-computed expected sequences for several request shapes.
module tb_gemm_tile_sequencer;
  import gemm_pkg::*;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  m_dim = '0, k_dim = '0, n_dim = '0;
  logic        in_ready, busy, done, err;
  logic        rd_en_A, rd_en_B, sa_clear, sa_feed, wr_en_C;
  logic [15:0] addr_A, addr_B, addr_C;
  logic [3:0]  row_mask, col_mask;
  logic [1:0]  sa_row_sel;
  state_t      dbg_state;

  int total = 0;
  int bad = 0;
  int feed_n, done_cyc, hits, err_n;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  logic [W-1:0] a_obs[$], b_obs[$], c_obs[$], mk_obs[$], clr_obs[$];

  gemm_tile_sequencer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .M_dimension(m_dim), .K_dimension(k_dim), .N_dimension(n_dim),
    .busy(busy), .done(done), .err(err),
    .rd_en_A(rd_en_A), .addr_A(addr_A), .rd_en_B(rd_en_B), .addr_B(addr_B),
    .sa_clear(sa_clear), .sa_feed(sa_feed), .row_mask(row_mask), .col_mask(col_mask),
    .sa_row_sel(sa_row_sel), .wr_en_C(wr_en_C), .addr_C(addr_C), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag);
    check({tag, "_len"}, W'(act_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), act_q[i], exp_q[i]);
  endtask

  task automatic exp_range(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(W'(base + i));
  endtask

  task automatic exp_rep(input int val, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(W'(val));
  endtask

  // drivers / monitor
  task automatic drive_accept(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n,
                              input bit hold);
    @(negedge clk);
    in_valid = 1'b1;
    m_dim = m;
    k_dim = k;
    n_dim = n;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic collect(input int budget);
    a_obs.delete(); b_obs.delete(); c_obs.delete(); mk_obs.delete(); clr_obs.delete();
    feed_n = 0;
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (rd_en_A) a_obs.push_back(addr_A);
      if (rd_en_B) b_obs.push_back(addr_B);
      if (sa_feed) feed_n++;
      if (sa_clear) clr_obs.push_back(addr_A);
      if (wr_en_C) begin
        c_obs.push_back(addr_C);
        mk_obs.push_back(W'({row_mask, col_mask}));
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_4x4x4(input string tag);
    act_q = a_obs; exp_q.delete(); exp_range(0, 4); check_q({tag, "_addr_a"});
    act_q = b_obs; exp_q.delete(); exp_range(0, 4); check_q({tag, "_addr_b"});
    act_q = clr_obs; exp_q.delete(); exp_rep(0, 1); check_q({tag, "_clear"});
    act_q = c_obs; exp_q.delete(); exp_range(0, 4); check_q({tag, "_addr_c"});
    act_q = mk_obs; exp_q.delete(); exp_rep('hFF, 4); check_q({tag, "_masks"});
    check({tag, "_feed_n"}, W'(feed_n), W'(4));
    check({tag, "_done_cyc"}, W'(done_cyc), W'(18));
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_enables", W'({rd_en_A, rd_en_B, sa_feed, sa_clear, wr_en_C}), W'(0));
    check("rst_addrs", addr_A | addr_B | addr_C, W'(0));
    check("rst_masks", W'({row_mask, col_mask, sa_row_sel}), W'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // 4x4x4: single full tile
    drive_accept(8'd4, 8'd4, 8'd4, 1'b0);
    collect(100);
    check_4x4x4("t1");
    @(posedge clk);
    #1;
    check("t1_done_pulse", W'(done), W'(0));
    check("t1_idle", W'(busy), W'(0));

    // M=6 N=5 K=3: 2x2 tiles with edge masks
    drive_accept(8'd6, 8'd3, 8'd5, 1'b0);
    collect(200);
    act_q = a_obs; exp_q.delete();
    exp_range(0, 3); exp_range(0, 3); exp_range(3, 3); exp_range(3, 3);
    check_q("t2_addr_a");
    act_q = b_obs; exp_q.delete();
    exp_range(0, 3); exp_range(3, 3); exp_range(0, 3); exp_range(3, 3);
    check_q("t2_addr_b");
    act_q = clr_obs; exp_q.delete();
    exp_rep(0, 2); exp_rep(3, 2);
    check_q("t2_clear");
    act_q = c_obs; exp_q.delete();
    exp_range(0, 4); exp_range(4, 4); exp_range(8, 2); exp_range(12, 2);
    check_q("t2_addr_c");
    act_q = mk_obs; exp_q.delete();
    exp_rep('hFF, 4); exp_rep('hF1, 4); exp_rep('h3F, 2); exp_rep('h31, 2);
    check_q("t2_masks");
    check("t2_feed_n", W'(feed_n), W'(12));
    check("t2_done_cyc", W'(done_cyc), W'(62));

    // K=0: error pulse only
    drive_accept(8'd4, 8'd0, 8'd4, 1'b0);
    check("t3_err", W'(err), W'(1));
    check("t3_busy", W'(busy), W'(0));
    hits = 0;
    err_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (busy || rd_en_A || rd_en_B || wr_en_C || sa_feed) hits++;
      if (err) err_n++;
    end
    check("t3_no_activity", W'(hits), W'(0));
    check("t3_err_once", W'(err_n), W'(0));

    // in_valid held with new dims during a run
    drive_accept(8'd4, 8'd4, 8'd4, 1'b1);
    m_dim = 8'd1;
    k_dim = 8'd1;
    n_dim = 8'd1;
    collect(100);
    check_4x4x4("t4a");
    check("t4_idle_at_done", W'({busy, in_ready}), W'(1));
    @(posedge clk);
    #1;
    check("t4_accept_next", W'(busy), W'(1));
    in_valid = 1'b0;
    collect(100);
    act_q = a_obs; exp_q.delete(); exp_rep(0, 1); check_q("t4b_addr_a");
    act_q = b_obs; exp_q.delete(); exp_rep(0, 1); check_q("t4b_addr_b");
    act_q = clr_obs; exp_q.delete(); exp_rep(0, 1); check_q("t4b_clear");
    act_q = c_obs; exp_q.delete(); exp_rep(0, 1); check_q("t4b_addr_c");
    act_q = mk_obs; exp_q.delete(); exp_rep('h11, 1); check_q("t4b_masks");
    check("t4b_feed_n", W'(feed_n), W'(1));
    check("t4b_done_cyc", W'(done_cyc), W'(15));

    // reset asserted mid-FEED
    drive_accept(8'd4, 8'd4, 8'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_feeding", W'(rd_en_A), W'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_drop", W'({rd_en_A, rd_en_B, sa_feed, wr_en_C, busy}), W'(0));
    check("t5_ready", W'(in_ready), W'(1));
    hits = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (wr_en_C || rd_en_A || busy) hits++;
    end
    check("t5_quiet_in_reset", W'(hits), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    drive_accept(8'd4, 8'd4, 8'd4, 1'b0);
    collect(100);
    check_4x4x4("t5b");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
- Parametrised successor to the fixed-size GEMM control path.
- Accepts a GEMM request with arbitrary M/K/N dimensions, up to 2^DIM_W-1 each, and tiles it onto a ROWS x COLS systolic array.
- Sequences A/B buffer reads, the array clear/feed/drain phases, and C buffer write-back per output tile.
- Masks partial edge tiles. Signals completion with a single-cycle done pulse.
- Sits between the request interface and the A/B/C SRAMs plus the systolic array.

Parameters:
- ROWS, 4, systolic array rows; also the number of A elements per A-buffer word.
- COLS, 4, systolic array columns; also the number of B elements per B-buffer word.
- DIM_W, 8, width of each dimension input.
- ADDR_WIDTH, 16, SRAM address width. Addresses wrap modulo 2^ADDR_WIDTH.
- SA_LAT, ROWS+COLS-1, cycles from the last feed cycle until the array output is stable.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, request can be accepted; equals !busy.
- M_dimension, input, DIM_W, rows of A and C.
- K_dimension, input, DIM_W, shared dimension.
- N_dimension, input, DIM_W, columns of B and C.
- busy, output, 1, state != IDLE.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle pulse when a request has a zero dimension.
- rd_en_A, output, 1, A buffer read enable.
- addr_A, output, ADDR_WIDTH, A word address = mt*K + k.
- rd_en_B, output, 1, B buffer read enable.
- addr_B, output, ADDR_WIDTH, B word address = nt*K + k.
- sa_clear, output, 1, clear array accumulators; high on the first feed cycle of each tile.
- sa_feed, output, 1, A/B words valid into the array this cycle.
- row_mask, output, ROWS, valid rows of the current tile.
- col_mask, output, COLS, valid columns of the current tile.
- sa_row_sel, output, clog2(ROWS), array output row being written back.
- wr_en_C, output, 1, C buffer write enable.
- addr_C, output, ADDR_WIDTH, C word address = (mt*NT + nt)*ROWS + r.

Behaviour:
- Reset (asynchronous) forces state IDLE and clears all counters. Every output is 0 except in_ready, which is 1. No write may occur after reset assertion.
- Accept condition: in_valid && in_ready at a rising edge.
  - Dimensions are latched on acceptance.
  - If any dimension is 0: err=1 for the next cycle, state stays IDLE, busy stays 0.
  - in_valid while busy is ignored.
- Tile counts: MT = ceil(M/ROWS), NT = ceil(N/COLS). Loop order: mt outer, nt inner, k innermost.
- Address generation uses incrementing base registers; no multipliers are required.
- States and transitions:
  - IDLE: on a valid accept -> SETUP.
  - SETUP (1 cycle): compute MT, NT and the edge-mask remainders -> FEED.
  - FEED (K cycles): rd_en_A=rd_en_B=sa_feed=1; k counts 0..K-1; sa_clear=1 only when k=0 -> DRAIN.
  - DRAIN (SA_LAT cycles): all enables 0 -> WRITE.
  - WRITE (ROWS cycles): sa_row_sel=r for r=0..ROWS-1; wr_en_C = row_mask[r]; addr_C is valid every cycle -> NEXT.
  - NEXT (1 cycle): advance nt, wrapping to 0 and incrementing mt. If the last tile is complete -> DONE, else -> FEED.
  - DONE (1 cycle): done=1 -> IDLE.
- Masks:
  - row_mask = all ones, except on the last mt: low (M - mt*ROWS) bits set.
  - col_mask: same rule using N and COLS.
  - Masks are held constant for the whole tile (FEED through WRITE).
- Latency: done is asserted at cycle 1 + MT*NT*(K+SA_LAT+ROWS+1) + 1 after the accept edge.
- All outputs are registered, except in_ready and busy, which are decoded from state.

Decomposition:
- Package gemm_pkg:
  - state enum (IDLE, SETUP, FEED, DRAIN, WRITE, NEXT, DONE);
  - ceil_div function;
  - default ROWS/COLS/SA_LAT constants.
- Sub-module gemm_loop_counter: a DIM_W-bit counter with a limit input, enable, clear and a wrap pulse. Instantiate it for k, the phase counter, nt and mt.

Test Plan:
- ROWS=COLS=4, M=K=N=4:
  - addr_A/addr_B go 0,1,2,3 during FEED;
  - sa_clear is high only on the first feed cycle;
  - wr_en_C at addr_C 0..3 with both masks 4'hF;
  - done pulses at cycle 18 after accept.
- M=6, N=5, K=3:
  - tiles visited in order (0,0),(0,1),(1,0),(1,1);
  - tile (1,1): addr_A 3..5, addr_B 3..5, row_mask 4'b0011, col_mask 4'b0001;
  - wr_en_C only at addr_C 12 and 13;
  - done at cycle 1 + 4*15 + 1 = 62.
- K_dimension=0: err pulses for one cycle; busy, rd_en_* and wr_en_C never assert.
- in_valid held high with new dimensions throughout a busy run:
  - the new request is ignored until done;
  - it is accepted on the first cycle after returning to IDLE.
- reset_n asserted mid-FEED:
  - all enables drop to 0 immediately (asynchronously), with no wr_en_C;
  - after release, a fresh 4x4x4 request completes normally with a correct address sequence.
- K=1 with M=N=1: single tile, one feed cycle with sa_clear=sa_feed=1, row_mask=col_mask=4'b0001, a single C write at addr_C 0.
